div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle sequencer for the DIV (alu_control 011) and REMU (alu_control 100) operations decoded by the processor's control unit. It owns a WIDTH-bit iterative restoring divider and runs it one quotient bit per cycle. While the divider runs it stalls the pipeline, then presents the quotient or remainder for one cycle so the EX stage can capture it. It sits beside the ALU in the execute stage; the hazard/stall logic ORs its `stall` output into the pipeline freeze.

## Interface
- `WIDTH`, default 32: operand and result width in bits.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: EX stage holds a valid instruction.
- `alu_control` input 3: ALU operation from the control unit. 011 selects DIV; 100 selects REMU; all other values are ignored.
- `dividend` input WIDTH: rs1 operand, unsigned.
- `divisor` input WIDTH: rs2 operand, unsigned.
- `flush` input 1: kill the in-flight operation (branch/jump flush).
- `stall` output 1: freezes the pipeline stages up to and including EX.
- `busy` output 1: registered; high in RUN.
- `result` output WIDTH: quotient for DIV, remainder for REMU.
- `result_valid` output 1: registered one-cycle pulse in DONE.

## Operation
- Both DIV and REMU are unsigned. Quotient and remainder are computed together, and `op` latched at accept selects which one drives `result`.
- State machine IDLE, RUN, DONE:
  - IDLE → RUN on accept, where accept = `start` & (`alu_control` ∈ {011, 100}) & ~`flush`. Accept latches the operands and `op`, clears the partial remainder, and loads the counter with WIDTH.
  - RUN: each cycle shifts {rem, quo} left by 1 and computes trial = rem − divisor. If there is no borrow, rem takes trial and the quotient bit is 1; otherwise the quotient bit is 0. The counter decrements, and the state moves to DONE when the counter reaches 1.
  - DONE: `result_valid` = 1 and `result` is valid. Always returns to IDLE next cycle. `start` is ignored in DONE because the same instruction is still in EX.
- `stall` = (IDLE & accept) | RUN. It is combinational in the accept cycle and 0 in DONE, so the instruction advances on the DONE edge.
- Divide by zero: quotient = all ones, remainder = dividend. The algorithm produces these values naturally; no special case is needed.
- `result` holds its last value after DONE until the next completion.
- `flush` in any state: next state IDLE, `busy` 0, no `result_valid`. `flush` beats `start` in the same cycle. `stall` is forced to 0 while `flush` = 1.
- Reset (`rst_n` = 0 at an edge): state IDLE, counter 0, `result` 0, `result_valid` 0, `busy` 0. While `rst_n` = 0, `stall` is forced to 0. Reset mid-RUN abandons the operation with no `result_valid`.

## Timing
- Accept at edge-cycle t. RUN occupies t+1 through t+WIDTH. DONE (`result_valid`) occurs at t+WIDTH+1, which is WIDTH+1 cycles of latency.
- `stall` is high for WIDTH+1 consecutive cycles (t through t+WIDTH), then low at t+WIDTH+1.
- Back-to-back divides: the earliest next accept is cycle t+WIDTH+2, in IDLE.
- Operands are sampled only at accept. Changes on `dividend`/`divisor` during RUN have no effect.
- Counter width is clog2(WIDTH+1). The subtraction is WIDTH+1 bits wide so the borrow is visible.

## Configuration
- `DIV_FAST_PATH_EN` defined: at accept, if `divisor` == 0 or `dividend` < `divisor`, go IDLE → DONE directly.
  - Divisor zero gives quotient all ones and remainder = `dividend`.
  - Dividend smaller than divisor gives quotient 0 and remainder = `dividend`.
  - `stall` is high only in the accept cycle; `result_valid` arrives at t+1.
  - The RUN path is unchanged for all other operands.
- Not defined: every accepted operation takes the full WIDTH+1-cycle path. Results are identical in both builds.

## Test plan
- DIV 100/7, WIDTH=32 → `stall` high for 33 cycles, `result_valid` at t+33, `result` = 14. Repeat as REMU → `result` = 2.
- DIV 0xFFFFFFFF/1 → 0xFFFFFFFF. REMU 0x80000000/0x80000001 → 0x80000000.
- DIV 55/0 → 0xFFFFFFFF; REMU 55/0 → 55. With `DIV_FAST_PATH_EN`, both complete with `result_valid` at t+1.
- `flush` asserted in RUN at t+10 → IDLE next cycle, no `result_valid`, `stall` low. A new DIV 9/3 accepted afterwards → 3.
- `start` with `alu_control` = 000 → `stall` 0, `busy` 0. `start` held high in DONE → no re-accept; an accept in the following cycle starts a new operation.
- `rst_n` low at t+5 of RUN → all outputs 0 next cycle, state IDLE, no `result_valid`.

Source files
------------

// File: rtl/div_sequencer.sv
// ----------------------------------------------------------------------------
// div_sequencer : iterative unsigned DIV/REMU sequencer, one quotient bit/cycle
// Optional: DIV_FAST_PATH_EN skips RUN when divisor==0 or dividend<divisor.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             op_rem;

  logic             accept;
  logic             fast_hit;
  logic [WIDTH-1:0] fast_result;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign accept = start & ((alu_control == 3'b011) | (alu_control == 3'b100)) & ~flush;

`ifdef DIV_FAST_PATH_EN
  assign fast_hit = (divisor == '0) | (dividend < divisor);
`else
  assign fast_hit = 1'b0;
`endif

  // Both shortcut cases leave the remainder equal to the dividend.
  assign fast_result = (alu_control == 3'b100) ? dividend :
                       (divisor == '0)         ? '1 : '0;

  // rem < dvsr holds between steps, so bit WIDTH of the difference is the borrow.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvsr};
  assign borrow   = diff[WIDTH];
  assign rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~borrow};

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = fast_hit ? DONE : RUN;
          stall   = 1'b1;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (cnt == CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      stall   = 1'b0;
    end
    if (!rst_n) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvsr         <= '0;
      op_rem       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy         <= (state_d == RUN);
      result_valid <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            rem    <= '0;
            quo    <= dividend;
            dvsr   <= divisor;
            op_rem <= (alu_control == 3'b100);
            cnt    <= CW'(WIDTH);
            if (state_d == DONE) result <= fast_result;
          end
        end
        RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt - CW'(1);
          if (state_d == DONE) result <= op_rem ? rem_next : quo_next;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer (WIDTH=32): directed DIV/REMU vectors,
// flush, reset and re-accept scenarios; a monitor checks every result_valid.
`default_nettype none

module tb_div_sequencer;

  localparam int W = 32;
`ifdef DIV_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   alu_control;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         stall;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] sb[$];

  div_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .alu_control  (alu_control),
    .dividend     (dividend),
    .divisor      (divisor),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // Monitor: every result_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        check("result", result, sb.pop_front());
      end
    end
  end

  task automatic run_op(input logic [2:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    int lat;
    int st;
    bit fast;
    fast = FAST && (b == '0 || a < b);
    @(posedge clk); #1;
    start = 1'b1; alu_control = ctl; dividend = a; divisor = b;
    sb.push_back(exp);
    @(negedge clk);
    st = stall ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 0;
    while (lat < 100) begin
      lat++;
      @(negedge clk);
      if (result_valid) break;
      if (stall) st++;
    end
    check("latency", lat, fast ? 1 : W + 1);
    check("stall_cycles", st, fast ? 1 : W + 1);
    check("stall_in_done", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("result_hold", result, exp);
    check("valid_pulse", {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=expired required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; alu_control = 3'b011;
    dividend = 32'd100; divisor = 32'd7; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(3'b011, 32'd100, 32'd7, 32'd14);
    run_op(3'b100, 32'd100, 32'd7, 32'd2);
    run_op(3'b011, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run_op(3'b100, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000);
    run_op(3'b011, 32'd55, 32'd0, 32'hFFFF_FFFF);
    run_op(3'b100, 32'd55, 32'd0, 32'd55);
    run_op(3'b011, 32'd1000, 32'd37, 32'd27);
    run_op(3'b100, 32'd1000, 32'd37, 32'd1);

    // Flush at t+10 of RUN: no result may appear.
    @(posedge clk); #1;
    start = 1'b1; alu_control = 3'b011; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_stall_after", {31'd0, stall}, 32'd0);
    repeat (40) @(posedge clk);
    run_op(3'b011, 32'd9, 32'd3, 32'd3);

    // Unsupported op and flush-vs-start: nothing accepted.
    @(posedge clk); #1;
    start = 1'b1; alu_control = 3'b000; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    check("nop_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    alu_control = 3'b011; flush = 1'b1;
    @(negedge clk);
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("flush_beats_start", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    // start held through DONE: re-accept only in the following IDLE cycle.
    @(posedge clk); #1;
    start = 1'b1; alu_control = 3'b011; dividend = 32'd20; divisor = 32'd4;
    sb.push_back(32'd5);
    sb.push_back(32'd5);
    begin
      int n = 0;
      while (n < 100) begin
        n++;
        @(negedge clk);
        if (result_valid) break;
      end
      check("hold_done_seen", {31'd0, result_valid}, 32'd1);
    end
    check("hold_done_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("reaccept_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("reaccept_busy", {31'd0, busy}, 32'd1);
    repeat (40) @(posedge clk);

    // Reset at t+5 of RUN.
    @(posedge clk); #1;
    start = 1'b1; alu_control = 3'b011; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rstrun_stall_forced", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstrun_busy", {31'd0, busy}, 32'd0);
    check("rstrun_valid", {31'd0, result_valid}, 32'd0);
    check("rstrun_result", result, 32'd0);
    check("rstrun_stall", {31'd0, stall}, 32'd0);
    repeat (40) @(posedge clk);

    run_op(3'b100, 32'd17, 32'd5, 32'd2);

    @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
